param_division_unit: RTL and testbench

//  Parametrised radix-2 non-restoring integer divider for the execute stage.

---
 rtl/param_division_unit_if.sv | 34 +++
 rtl/param_division_unit.sv | 202 ++++++++++++++++++++
 tb/tb_param_division_unit.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/param_division_unit_if.sv
// +----------------------------------------------------------------------------+
// | Module      : param_division_unit_if                                      |
// | Description : Request/response handshake bundle for param_division_unit. |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

interface param_division_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             valid_i;
    logic             ready_o;
    logic [1:0]       islem_i;
    logic [XLEN-1:0]  bolunen_i;
    logic [XLEN-1:0]  bolen_i;
    logic [TAG_W-1:0] tag_i;
    logic             valid_o;
    logic             ready_i;
    logic [XLEN-1:0]  sonuc_o;
    logic [TAG_W-1:0] tag_o;

    modport slave (
        input  valid_i, islem_i, bolunen_i, bolen_i, tag_i, ready_i,
        output ready_o, valid_o, sonuc_o, tag_o
    );

    modport master (
        output valid_i, islem_i, bolunen_i, bolen_i, tag_i, ready_i,
        input  ready_o, valid_o, sonuc_o, tag_o
    );
endinterface

`default_nettype wire

// File: rtl/param_division_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : param_division_unit                                         |
// | Description : Radix-2 non-restoring DIV/DIVU/REM/REMU with tag, flush and |
// |               exact divide-by-zero / overflow results.                    |
// |               Optional: define DIV_FAST_PATH_EN for 1-cycle trivial ops.  |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module param_division_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    input  wire logic            flush_i,
    output logic                 busy_o,
    param_division_unit_if.slave bus
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CW-1:0]   c_count_init = CW'(XLEN);
    localparam logic [CW-1:0]   c_count_last = CW'(1);
    localparam logic [XLEN-1:0] c_int_min    = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;

    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_div_zero;
    logic             r_ovf;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN:0]    r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_div;
    logic [CW-1:0]    r_count;
    logic [XLEN-1:0]  r_sonuc;
    logic [TAG_W-1:0] r_tag_o;

    logic             w_accept;
    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_abs_a;
    logic [XLEN-1:0]  w_abs_b;
    logic             w_div_zero;
    logic             w_ovf;
    logic             w_fast;
    logic [XLEN-1:0]  w_fast_res;

    logic [XLEN:0]    w_shift;
    logic [XLEN:0]    w_rem_next;
    logic [XLEN-1:0]  w_rem_mag;
    logic [XLEN-1:0]  w_q_final;
    logic [XLEN-1:0]  w_r_final;
    logic [XLEN-1:0]  w_fix_res;

    logic             w_ready_o;
    logic             w_valid_o;
    logic             w_busy_o;

    // Request decode: even opcodes are the signed variants.
    assign w_accept   = (r_state == S_IDLE) && bus.valid_i && !flush_i;
    assign w_signed   = ~bus.islem_i[0];
    assign w_a_neg    = w_signed & bus.bolunen_i[XLEN-1];
    assign w_b_neg    = w_signed & bus.bolen_i[XLEN-1];
    assign w_abs_a    = w_a_neg ? -bus.bolunen_i : bus.bolunen_i;
    assign w_abs_b    = w_b_neg ? -bus.bolen_i   : bus.bolen_i;
    assign w_div_zero = (bus.bolen_i == '0);
    assign w_ovf      = w_signed && (bus.bolunen_i == c_int_min) && (bus.bolen_i == '1);

`ifdef DIV_FAST_PATH_EN
    logic [XLEN-1:0] w_fast_q;
    logic [XLEN-1:0] w_fast_r;

    assign w_fast   = w_div_zero | w_ovf | (bus.bolunen_i == '0) | (w_abs_a < w_abs_b);
    assign w_fast_q = w_div_zero ? '1 : (w_ovf ? c_int_min : '0);
    assign w_fast_r = (w_ovf && !w_div_zero) ? '0 : bus.bolunen_i;
    assign w_fast_res = bus.islem_i[1] ? w_fast_r : w_fast_q;
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    // Iteration step; arithmetic is modulo 2^(XLEN+1), which is exact because
    // the partial remainder always lands back inside [-d, d).
    assign w_shift    = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
    assign w_rem_next = r_rem[XLEN] ? (w_shift + {1'b0, r_div})
                                    : (w_shift - {1'b0, r_div});

    assign w_rem_mag  = r_rem[XLEN] ? (r_rem[XLEN-1:0] + r_div) : r_rem[XLEN-1:0];
    assign w_q_final  = r_div_zero ? '1 :
                        r_ovf      ? c_int_min :
                        (r_neg_q ? -r_quo : r_quo);
    assign w_r_final  = r_ovf ? '0 : (r_neg_r ? -w_rem_mag : w_rem_mag);
    assign w_fix_res  = r_is_rem ? w_r_final : w_q_final;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush_i) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.valid_i) w_next_state = w_fast ? S_DONE : S_CALC;
                S_CALC:  if (r_count == c_count_last) w_next_state = S_FIX;
                S_FIX:   w_next_state = S_DONE;
                S_DONE:  if (bus.ready_i) w_next_state = S_IDLE;
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_ready_o = 1'b0;
        w_valid_o = 1'b0;
        w_busy_o  = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_ready_o = 1'b1;
                w_busy_o  = 1'b0;
            end
            S_DONE:  w_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_is_rem   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_tag      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_div      <= '0;
            r_count    <= '0;
            r_sonuc    <= '0;
            r_tag_o    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_rem   <= bus.islem_i[1];
                        r_neg_q    <= w_a_neg ^ w_b_neg;
                        r_neg_r    <= w_a_neg;
                        r_div_zero <= w_div_zero;
                        r_ovf      <= w_ovf;
                        r_tag      <= bus.tag_i;
                        r_rem      <= '0;
                        r_quo      <= w_abs_a;
                        r_div      <= w_abs_b;
                        r_count    <= c_count_init;
                        if (w_fast) begin
                            r_sonuc <= w_fast_res;
                            r_tag_o <= bus.tag_i;
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= w_rem_next;
                    r_quo   <= {r_quo[XLEN-2:0], ~w_rem_next[XLEN]};
                    r_count <= r_count - c_count_last;
                end
                S_FIX: begin
                    // A flushed op must leave the visible result untouched.
                    if (!flush_i) begin
                        r_sonuc <= w_fix_res;
                        r_tag_o <= r_tag;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready_o = w_ready_o;
    assign bus.valid_o = w_valid_o;
    assign bus.sonuc_o = r_sonuc;
    assign bus.tag_o   = r_tag_o;
    assign busy_o      = w_busy_o;

endmodule

`default_nettype wire

// File: tb/tb_param_division_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_param_division_unit                                      |
// | Description : Directed and random self-checking bench for the divider.    |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_param_division_unit;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef DIV_FAST_PATH_EN
    localparam bit FAST_PATH = 1'b1;
`else
    localparam bit FAST_PATH = 1'b0;
`endif
    localparam logic [XLEN-1:0] INT_MIN = 32'h8000_0000;

    logic clk_i = 1'b0;
    logic rst_i;
    logic flush_i;
    logic busy_o;

    int n_checks = 0;
    int n_errors = 0;

    param_division_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    param_division_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .busy_o  (busy_o),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Architectural result of an M-extension divide, straight from the ISA rules.
    function automatic logic [XLEN-1:0] ref_result(input logic [1:0] op,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        longint sa, sb;
        logic [XLEN-1:0] q, r;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (!op[0]) begin
            sa = $signed(a);
            sb = $signed(b);
            if (a == INT_MIN && sb == -1) begin
                q = a;
                r = '0;
            end else begin
                q = XLEN'(sa / sb);
                r = XLEN'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    function automatic int exp_latency(input logic [1:0] op,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
        longint ma, mb;
        bit trivial;
        ma = op[0] ? longint'(a) : longint'($signed(a));
        mb = op[0] ? longint'(b) : longint'($signed(b));
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
        trivial = (b == 0) || (!op[0] && a == INT_MIN && b == '1) || (a == 0) || (ma < mb);
        return (FAST_PATH && trivial) ? 1 : XLEN + 2;
    endfunction

    // Present a request at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag);
        int guard = 0;
        while (!bus.ready_o && guard < 100) begin
            @(negedge clk_i);
            guard++;
        end
        check("ready_before_issue", bus.ready_o, 1);
        bus.valid_i   = 1'b1;
        bus.islem_i   = op;
        bus.bolunen_i = a;
        bus.bolen_i   = b;
        bus.tag_i     = tag;
        @(posedge clk_i);
        @(negedge clk_i);
        bus.valid_i   = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [TAG_W-1:0] tag,
                          input string name, input int hold);
        logic [XLEN-1:0] expv;
        int lat;
        expv = ref_result(op, a, b);
        issue(op, a, b, tag);
        lat = 1;
        while (!bus.valid_o && lat < 200) begin
            @(negedge clk_i);
            lat++;
        end
        check({name, "_valid"},   bus.valid_o, 1);
        check({name, "_result"},  bus.sonuc_o, expv);
        check({name, "_tag"},     bus.tag_o, tag);
        check({name, "_latency"}, lat, exp_latency(op, a, b));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            check({name, "_hold_valid"},  bus.valid_o, 1);
            check({name, "_hold_result"}, bus.sonuc_o, expv);
            check({name, "_hold_tag"},    bus.tag_o, tag);
            check({name, "_hold_ready"},  bus.ready_o, 0);
        end
        bus.ready_i = 1'b1;
        @(negedge clk_i);
        bus.ready_i = 1'b0;
        check({name, "_release_valid"}, bus.valid_o, 0);
        check({name, "_release_ready"}, bus.ready_o, 1);
    endtask

    initial begin
        logic [1:0]       op;
        logic [XLEN-1:0]  a, b;
        logic [TAG_W-1:0] tag;
        bit               seen;

        rst_i         = 1'b1;
        flush_i       = 1'b0;
        bus.valid_i   = 1'b0;
        bus.ready_i   = 1'b0;
        bus.islem_i   = 2'b00;
        bus.bolunen_i = '0;
        bus.bolen_i   = '0;
        bus.tag_i     = '0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", bus.ready_o, 1);
        check("rst_valid", bus.valid_o, 0);
        check("rst_busy",  busy_o, 0);
        check("rst_sonuc", bus.sonuc_o, 0);
        check("rst_tag",   bus.tag_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Directed arithmetic and special cases
        run_op(2'b01, 32'd100, 32'd7, 5'd1, "divu_100_7", 0);
        run_op(2'b11, 32'd100, 32'd7, 5'd2, "remu_100_7", 0);
        run_op(2'b00, -32'sd7, 32'd2, 5'd3, "div_m7_2", 0);
        run_op(2'b10, -32'sd7, 32'd2, 5'd4, "rem_m7_2", 0);
        run_op(2'b10, 32'd7, -32'sd2, 5'd5, "rem_7_m2", 0);
        run_op(2'b00, 32'd12345, 32'd0, 5'd6, "div_by_zero", 0);
        run_op(2'b11, 32'h1234, 32'd0, 5'd7, "remu_by_zero", 0);
        run_op(2'b00, INT_MIN, 32'hFFFF_FFFF, 5'd8, "div_overflow", 0);
        run_op(2'b10, INT_MIN, 32'hFFFF_FFFF, 5'd9, "rem_overflow", 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd10, "divu_max_1", 0);

        // Busy while iterating
        issue(2'b01, 32'd5000, 32'd3, 5'd11);
        check("calc_busy",  busy_o, 1);
        check("calc_ready", bus.ready_o, 0);
        bus.ready_i = 1'b1;
        repeat (XLEN + 4) @(negedge clk_i);
        bus.ready_i = 1'b0;

        // Backpressure followed by a back-to-back request
        run_op(2'b01, 32'd500, 32'd9, 5'd12, "backpressure", 10);
        run_op(2'b00, -32'sd1000, 32'd33, 5'd13, "back_to_back", 0);

        // Flush mid-calculation discards the result
        issue(2'b01, 32'd1000, 32'd3, 5'd5);
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush_busy",  busy_o, 0);
        check("flush_ready", bus.ready_o, 1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk_i);
            if (bus.valid_o) seen = 1'b1;
        end
        check("flush_no_valid", seen, 0);

        // Flush beats a simultaneous request
        bus.valid_i   = 1'b1;
        bus.islem_i   = 2'b01;
        bus.bolunen_i = 32'd77;
        bus.bolen_i   = 32'd5;
        bus.tag_i     = 5'd20;
        flush_i       = 1'b1;
        @(negedge clk_i);
        bus.valid_i = 1'b0;
        flush_i     = 1'b0;
        check("flush_blocks_accept", busy_o, 0);

        run_op(2'b00, -32'sd100, 32'd7, 5'd6, "post_flush", 0);

        // Asynchronous reset in the middle of an operation
        issue(2'b01, 32'hFFFF, 32'd3, 5'd9);
        repeat (4) @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("arst_ready", bus.ready_o, 1);
        check("arst_valid", bus.valid_o, 0);
        check("arst_busy",  busy_o, 0);
        check("arst_sonuc", bus.sonuc_o, 0);
        check("arst_tag",   bus.tag_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Random operations against the reference model
        for (int n = 0; n < 1500; n++) begin
            op  = 2'($urandom_range(0, 3));
            tag = TAG_W'($urandom);
            case ($urandom_range(0, 7))
                0: begin a = $urandom; b = '0; end
                1: begin a = INT_MIN; b = '1; end
                2: begin a = $urandom_range(0, 255); b = $urandom_range(1, 255); end
                3: begin a = $urandom; b = $urandom_range(1, 15); end
                4: begin a = $urandom_range(0, 100); b = $urandom; end
                5: begin a = $urandom; b = -($urandom_range(1, 300)); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op(op, a, b, tag, "random", 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
